// File: rtl/fp_access_ctrl.sv
// Access front end for a faulty data RAM: plain pass-through, byte-half swap for flip words,
// spare-word redirect for patch words. Optional FP_ACCESS_STATS_EN adds per-class response counters.
module fp_access_ctrl #(
   parameter int N_WORDS       = 1 << 20,
   parameter int DATA_W        = 16,
   parameter int ADDR_W        = $clog2(N_WORDS),
   parameter int PATCH_ENTRIES = 16,
   parameter int PU_W          = $clog2(PATCH_ENTRIES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              map_we_i,
   input  logic [ADDR_W-1:0] map_addr_i,
   input  logic              map_flip_i,
   input  logic              map_patch_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [PU_W-1:0]   patch_used_o,
   output logic              patch_overflow_o
`ifdef FP_ACCESS_STATS_EN
   ,
   output logic [31:0]       stat_plain_o,
   output logic [31:0]       stat_flip_o,
   output logic [31:0]       stat_patch_o
`endif
);

   localparam int IDX_W = (PATCH_ENTRIES > 1) ? $clog2(PATCH_ENTRIES) : 1;
   localparam int H     = DATA_W / 2;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [1:0] {CL_PLAIN, CL_FLIP, CL_PATCH} cls_t;

   state_t state_q, state_d;
   cls_t   cls_d, cls_q;

   logic              flip_q  [N_WORDS];
   logic [ADDR_W-1:0] tag_q   [PATCH_ENTRIES];
   logic [DATA_W-1:0] pdata_q [PATCH_ENTRIES];
   logic [PATCH_ENTRIES-1:0] pvld_q;
   logic [PU_W-1:0]   used_q;
   logic              ovf_q;
   logic              init_q;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;

   logic              map_hit, req_hit, free_ok;
   logic [IDX_W-1:0]  req_idx, free_idx;
   logic              map_acc, alloc, full, accept;

   // Descending scan so the lowest matching / free entry wins.
   always_comb begin
      map_hit  = 1'b0;
      req_hit  = 1'b0;
      req_idx  = '0;
      free_ok  = 1'b0;
      free_idx = '0;
      for (int i = PATCH_ENTRIES - 1; i >= 0; i--) begin
         if (pvld_q[i] && tag_q[i] == map_addr_i) map_hit = 1'b1;
         if (pvld_q[i] && tag_q[i] == addr_q) begin
            req_hit = 1'b1;
            req_idx = IDX_W'(i);
         end
         if (!pvld_q[i]) begin
            free_ok  = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign full    = (used_q == PU_W'(PATCH_ENTRIES)) || !free_ok;
   assign map_acc = map_we_i && init_q && (state_q == IDLE);
   assign alloc   = map_acc && map_patch_i && !map_hit && !full;
   assign accept  = req_valid_i && req_ready_o;

   always_comb begin
      cls_d = CL_PLAIN;
      if (req_hit)             cls_d = CL_PATCH;
      else if (flip_q[addr_q]) cls_d = CL_FLIP;
   end

   always_comb begin
      rdata_d = '0;
      if (!we_q) begin
         case (cls_d)
            CL_PATCH: rdata_d = pdata_q[req_idx];
            CL_FLIP:  rdata_d = {mem_rdata_i[H-1:0], mem_rdata_i[DATA_W-1:H]};
            default:  rdata_d = mem_rdata_i;
         endcase
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready_o = init_q && (state_q == IDLE) && !map_we_i;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      rsp_valid_o = 1'b0;
      rsp_rdata_o = '0;
      if (state_q == ACCESS) begin
         mem_addr_o = addr_q;
         if (we_q && cls_d != CL_PATCH) begin
            mem_we_o    = 1'b1;
            mem_wdata_o = (cls_d == CL_FLIP) ? {wdata_q[H-1:0], wdata_q[DATA_W-1:H]} : wdata_q;
         end
      end
      if (state_q == RESP) begin
         rsp_valid_o = 1'b1;
         rsp_rdata_o = rdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_WORDS; i++) flip_q[i] <= 1'b0;
      end else if (map_acc && map_flip_i) begin
         flip_q[map_addr_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PATCH_ENTRIES; i++) begin
            tag_q[i]   <= '0;
            pdata_q[i] <= '0;
         end
         pvld_q <= '0;
         used_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (alloc) begin
            tag_q[free_idx]   <= map_addr_i;
            pdata_q[free_idx] <= '0;
            pvld_q[free_idx]  <= 1'b1;
            used_q            <= used_q + 1'b1;
         end
         if (map_acc && map_patch_i && !map_hit && full) ovf_q <= 1'b1;
         if (state_q == ACCESS && we_q && req_hit) pdata_q[req_idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cls_q   <= CL_PLAIN;
      end else begin
         init_q <= 1'b1;
         if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (state_q == ACCESS) begin
            rdata_q <= rdata_d;
            cls_q   <= cls_d;
         end
      end
   end

   assign patch_used_o     = used_q;
   assign patch_overflow_o = ovf_q;

`ifdef FP_ACCESS_STATS_EN
   logic [31:0] st_plain_q, st_flip_q, st_patch_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_plain_q <= '0;
         st_flip_q  <= '0;
         st_patch_q <= '0;
      end else if (state_q == RESP) begin
         case (cls_q)
            CL_PATCH: if (st_patch_q != '1) st_patch_q <= st_patch_q + 1'b1;
            CL_FLIP:  if (st_flip_q  != '1) st_flip_q  <= st_flip_q  + 1'b1;
            default:  if (st_plain_q != '1) st_plain_q <= st_plain_q + 1'b1;
         endcase
      end
   end
   assign stat_plain_o = st_plain_q;
   assign stat_flip_o  = st_flip_q;
   assign stat_patch_o = st_patch_q;
`endif

endmodule
